// File: rtl/debuger_decoder_spec_if.sv
// UART/snapshot side of the debug command decoder.
// master = decoder, slave = UART transceiver plus snapshot memory.
interface debuger_decoder_spec_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_done;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] dump_addr;
    logic [7:0]        dump_data;

    modport master (
        input  rx_data, rx_done, tx_busy, tx_done, dump_data,
        output tx_start, tx_data, dump_addr
    );

    modport slave (
        output rx_data, rx_done, tx_busy, tx_done, dump_data,
        input  tx_start, tx_data, dump_addr
    );
endinterface

// File: rtl/debuger_decoder_spec.sv
// Debug command decoder: run/stop/step/reset of the MIPS pipeline and
// byte-wise dump of the debug snapshot over the UART.
//
//   state       | meaning
//   S_HALT      | pipeline stopped, accepting c/n/r/d
//   S_RUN       | pipeline clock-enabled, accepting s/r
//   S_DUMP_LOAD | waiting for tx idle, then launch byte at dump index
//   S_DUMP_WAIT | byte in flight, waiting for tx_done
module debuger_decoder_spec #(
    parameter int DUMP_LEN = 16,
    parameter int ADDR_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    debuger_decoder_spec_if.master  bus,
    output logic                    cpu_enable,
    output logic                    cpu_reset
);
    localparam logic [7:0] CMD_CONT  = 8'h63;
    localparam logic [7:0] CMD_STOP  = 8'h73;
    localparam logic [7:0] CMD_STEP  = 8'h6E;
    localparam logic [7:0] CMD_RESET = 8'h72;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_LEN - 1);

    typedef enum logic [1:0] {
        S_HALT      = 2'd0,
        S_RUN       = 2'd1,
        S_DUMP_LOAD = 2'd2,
        S_DUMP_WAIT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_tx_data_nxt;
    logic              r_tx_start;
    logic              w_tx_start_nxt;
    logic              r_cpu_enable;
    logic              w_cpu_enable_nxt;
    logic              r_cpu_reset;
    logic              w_cpu_reset_nxt;

    logic w_cmd_cont, w_cmd_stop, w_cmd_step, w_cmd_reset, w_cmd_dump;
    logic w_last;

    assign w_cmd_cont  = bus.rx_done && (bus.rx_data == CMD_CONT);
    assign w_cmd_stop  = bus.rx_done && (bus.rx_data == CMD_STOP);
    assign w_cmd_step  = bus.rx_done && (bus.rx_data == CMD_STEP);
    assign w_cmd_reset = bus.rx_done && (bus.rx_data == CMD_RESET);
    assign w_cmd_dump  = bus.rx_done && (bus.rx_data == CMD_DUMP);
    assign w_last      = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HALT;
            r_idx        <= '0;
            r_tx_data    <= 8'h00;
            r_tx_start   <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_cpu_reset  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_cpu_enable <= w_cpu_enable_nxt;
            r_cpu_reset  <= w_cpu_reset_nxt;
        end
    end

    // Dump states never look at rx_done, so commands during a dump are dropped.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_HALT: begin
                if (w_cmd_reset)     w_state_nxt = S_HALT;
                else if (w_cmd_cont) w_state_nxt = S_RUN;
                else if (w_cmd_dump) w_state_nxt = S_DUMP_LOAD;
            end
            S_RUN: begin
                if (w_cmd_stop || w_cmd_reset) w_state_nxt = S_HALT;
            end
            S_DUMP_LOAD: begin
                if (!bus.tx_busy) w_state_nxt = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (bus.tx_done) w_state_nxt = w_last ? S_HALT : S_DUMP_LOAD;
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        w_cpu_enable_nxt = (w_state_nxt == S_RUN) || ((r_state == S_HALT) && w_cmd_step);
        w_cpu_reset_nxt  = ((r_state == S_HALT) || (r_state == S_RUN)) && w_cmd_reset;
        w_tx_start_nxt   = (r_state == S_DUMP_LOAD) && !bus.tx_busy;
        w_tx_data_nxt    = w_tx_start_nxt ? bus.dump_data : r_tx_data;
        w_idx_nxt        = r_idx;
        if ((r_state == S_HALT) && w_cmd_dump && !w_cmd_reset) begin
            w_idx_nxt = '0;
        end else if ((r_state == S_DUMP_WAIT) && bus.tx_done) begin
            w_idx_nxt = w_last ? '0 : r_idx + ADDR_W'(1);
        end
    end

    assign bus.tx_start  = r_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign bus.dump_addr = r_idx;
    assign cpu_enable    = r_cpu_enable;
    assign cpu_reset     = r_cpu_reset;
endmodule

// File: tb/tb_debuger_decoder_spec.sv
// Bench for the debug command decoder: directed scenarios then random
// command streams against a run/halt + expected-byte-list reference.
module tb_debuger_decoder_spec;
    localparam int DUMP_LEN = 16;
    localparam int ADDR_W   = 8;

    logic       clk = 1'b1;
    logic       reset;
    logic       cpu_enable;
    logic       cpu_reset;
    logic [7:0] dump_base = 8'h10;
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         tx_pulses = 0;
    bit         running   = 1'b0;

    debuger_decoder_spec_if #(.ADDR_W(ADDR_W)) bus ();

    debuger_decoder_spec #(.DUMP_LEN(DUMP_LEN), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_enable (cpu_enable),
        .cpu_reset  (cpu_reset)
    );

    always #1 clk = ~clk;

    // Snapshot memory: zero-latency byte = address + per-dump base.
    assign bus.dump_data = 8'(bus.dump_addr) + dump_base;

    always @(negedge clk) if (bus.tx_start === 1'b1) tx_pulses <= tx_pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag, input bit exp_en);
        chk({tag, "_en"},    32'(cpu_enable),   32'(exp_en));
        chk({tag, "_rst"},   32'(cpu_reset),    32'd0);
        chk({tag, "_start"}, 32'(bus.tx_start), 32'd0);
    endtask

    function automatic logic [7:0] pick_cmd();
        logic [7:0] b;
        case ($urandom_range(0, 6))
            0: b = 8'h63;
            1: b = 8'h73;
            2: b = 8'h6E;
            3: b = 8'h72;
            4: b = 8'h64;
            default: begin
                b = 8'($urandom);
                while (b == 8'h63 || b == 8'h73 || b == 8'h6E || b == 8'h72 || b == 8'h64)
                    b = 8'($urandom);
            end
        endcase
        return b;
    endfunction

    task automatic send(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    // Called at the negedge right after 'd' was accepted in HALT.
    task automatic do_dump(input int reset_at);
        int p0;
        int exp_pulses;
        p0 = tx_pulses;
        exp_pulses = (reset_at >= 0) ? reset_at + 1 : DUMP_LEN;
        chk("dump_addr0", 32'(bus.dump_addr), 32'd0);
        chk_quiet("dump_entry", 1'b0);
        for (int i = 0; i < DUMP_LEN; i++) begin
            int k;
            int w;
            k = $urandom_range(0, 2);
            if (k > 0) begin
                bus.tx_busy = 1'b1;
                repeat (k) begin
                    tick();
                    chk("busy_hold_start", 32'(bus.tx_start), 32'd0);
                end
            end
            bus.tx_busy = 1'b0;
            tick();
            chk("tx_start",  32'(bus.tx_start),  32'd1);
            chk("tx_data",   32'(bus.tx_data),   32'(8'(i) + dump_base));
            chk("dump_addr", 32'(bus.dump_addr), 32'(i));
            chk("dump_en",   32'(cpu_enable),    32'd0);
            bus.tx_busy = 1'b1;
            w = $urandom_range(1, 3);
            for (int j = 0; j < w; j++) begin
                if ((i == reset_at && j == 0) || $urandom_range(0, 1) == 1) begin
                    bus.rx_data = (i == reset_at && j == 0) ? 8'h63 : pick_cmd();
                    bus.rx_done = 1'b1;
                end
                tick();
                bus.rx_done = 1'b0;
                chk_quiet("dump_wait", 1'b0);
                chk("wait_addr", 32'(bus.dump_addr), 32'(i));
            end
            if (i == reset_at) begin
                reset = 1'b1;
                tick();
                chk_quiet("abort", 1'b0);
                chk("abort_data", 32'(bus.tx_data),   32'd0);
                chk("abort_addr", 32'(bus.dump_addr), 32'd0);
                tick();
                reset = 1'b0;
                bus.tx_busy = 1'b0;
                repeat (20) begin
                    tick();
                    chk_quiet("post_abort", 1'b0);
                    chk("post_abort_addr", 32'(bus.dump_addr), 32'd0);
                end
                running = 1'b0;
                chk("abort_pulses", 32'(tx_pulses - p0), 32'(exp_pulses));
                return;
            end
            bus.tx_done = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                bus.rx_data = pick_cmd();
                bus.rx_done = 1'b1;
            end
            tick();
            bus.tx_done = 1'b0;
            bus.rx_done = 1'b0;
            bus.tx_busy = 1'b0;
            chk_quiet("after_done", 1'b0);
            chk("next_addr", 32'(bus.dump_addr), (i == DUMP_LEN - 1) ? 32'd0 : 32'(i + 1));
        end
        repeat (6) begin
            tick();
            chk_quiet("dump_tail", 1'b0);
            chk("tail_addr", 32'(bus.dump_addr), 32'd0);
        end
        chk("dump_pulses", 32'(tx_pulses - p0), 32'(exp_pulses));
    endtask

    // Reference: running flag; one command, then its expected aftermath.
    task automatic exec(input logic [7:0] cmd, input logic [7:0] base, input int reset_at);
        if (cmd == 8'h64 && !running) dump_base = base;
        send(cmd);
        case (cmd)
            8'h63: begin
                running = 1'b1;
                chk_quiet("cont", 1'b1);
            end
            8'h73: begin
                running = 1'b0;
                chk_quiet("stop", 1'b0);
            end
            8'h6E: begin
                chk_quiet("step", 1'b1);
                if (!running) begin
                    tick();
                    chk_quiet("step_end", 1'b0);
                end
            end
            8'h72: begin
                running = 1'b0;
                chk("rst_pulse", 32'(cpu_reset),  32'd1);
                chk("rst_en",    32'(cpu_enable), 32'd0);
                tick();
                chk_quiet("rst_end", 1'b0);
            end
            8'h64: begin
                if (running) chk_quiet("dump_in_run", 1'b1);
                else         do_dump(reset_at);
            end
            default: chk_quiet("other", running);
        endcase
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk_quiet("idle", running);
            chk("idle_addr", 32'(bus.dump_addr), 32'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        #9;
        reset = 1'b0;
        chk_quiet("reset", 1'b0);
        chk("reset_data", 32'(bus.tx_data),   32'd0);
        chk("reset_addr", 32'(bus.dump_addr), 32'd0);
        repeat (10) begin
            tick();
            chk_quiet("post_reset", 1'b0);
            chk("post_reset_addr", 32'(bus.dump_addr), 32'd0);
        end

        exec(8'h63, 8'h00, -1);
        repeat (4) begin
            tick();
            chk_quiet("run_hold", 1'b1);
        end
        exec(8'h73, 8'h00, -1);
        exec(8'h73, 8'h00, -1);
        repeat (3) exec(8'h6E, 8'h00, -1);
        exec(8'h64, 8'h10, -1);
        exec(8'h63, 8'h00, -1);
        exec(8'h6E, 8'h00, -1);
        exec(8'h64, 8'h00, -1);
        exec(8'h72, 8'h00, -1);
        exec(8'h6E, 8'h00, -1);
        exec(8'h64, 8'($urandom), 5);

        for (int n = 0; n < 80; n++) begin
            logic [7:0] c;
            c = pick_cmd();
            if (c == 8'h64 && $urandom_range(0, 2) != 0) c = 8'h6E;
            exec(c, 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DUMP_LEN - 1)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
